// File: rtl/aes_pipe_sched_pkg.sv
// ----------------------------------------------------------------------------
// aes_pipe_sched_pkg
// Shared constants and types for the AES pipeline scheduler slice.
//   BLOCK_W            : AES block / key width in bits
//   LAT_DEFAULT        : default fixed latency of the external AES pipeline
//   FIFO_DEPTH_DEFAULT : default depth of the response FIFO
//   TAG_W_DEFAULT      : default width of the opaque requester tag
//   src_e              : identifies which requester a block came from
//   rsp_rec_t          : response record {data, src, tag} at default tag width
//   rr_pick()          : round-robin choice between the two requesters
// ----------------------------------------------------------------------------
package aes_pipe_sched_pkg;

    localparam int BLOCK_W            = 128;
    localparam int LAT_DEFAULT        = 11;
    localparam int FIFO_DEPTH_DEFAULT = 16;
    localparam int TAG_W_DEFAULT      = 4;

    typedef enum logic {
        SRC_REQ0 = 1'b0,
        SRC_REQ1 = 1'b1
    } src_e;

    typedef struct packed {
        logic [BLOCK_W-1:0]       data;
        logic                     src;
        logic [TAG_W_DEFAULT-1:0] tag;
    } rsp_rec_t;

    // With both requesters asking, the one that did not win last time gets
    // the slot; with a single requester asking, it simply wins. When nobody
    // asks the answer is irrelevant because nothing is accepted.
    function automatic src_e rr_pick(input logic v0, input logic v1, input src_e last);
        if (v0 && v1) begin
            return (last == SRC_REQ0) ? SRC_REQ1 : SRC_REQ0;
        end else if (v1) begin
            return SRC_REQ1;
        end else begin
            return SRC_REQ0;
        end
    endfunction

endpackage

// File: rtl/aes_rsp_fifo.sv
// ----------------------------------------------------------------------------
// aes_rsp_fifo
// First-word-fall-through FIFO holding finished AES responses.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset (clears pointers and count)
//   wr_en    : write wr_data at the end of this cycle
//   wr_data  : packed response record
//   rd_en    : pop the head entry at the end of this cycle
//   rd_data  : head entry, valid whenever empty is 0
//   empty    : FIFO holds no entries
//   count    : number of entries currently held
// Storage is deliberately left unreset; only the bookkeeping is cleared.
// ----------------------------------------------------------------------------
module aes_rsp_fifo
    import aes_pipe_sched_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int WIDTH = BLOCK_W + 1 + TAG_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    // The scheduler's credit rule already keeps writes off a full FIFO;
    // the full/empty guards just make the FIFO safe on its own.
    always_comb begin
        empty = (cnt == '0);
        full  = (cnt == (AW + 1)'(DEPTH));
        do_wr = wr_en && !full;
        do_rd = rd_en && !empty;
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    // A write and a pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + (AW + 1)'(1);
                2'b01:   cnt <= cnt - (AW + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage, no reset needed: stale entries are never visible
    // because the count says they are not there.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

endmodule

// File: rtl/aes_pipe_sched.sv
// ----------------------------------------------------------------------------
// aes_pipe_sched
// Shares one fixed-latency AES pipeline between two requesters. Blocks are
// granted round-robin, handed to the pipeline, tracked through a LAT-deep
// shift register, and their ciphertexts are parked in a response FIFO.
// Ports:
//   clk, reset                    : clock (rising edge), async active-low reset
//   reqN_valid/ready              : requester N handshake (accept = both high)
//   reqN_data/key/tag             : plaintext, key and opaque tag of requester N
//   pipe_data/pipe_key            : block driven into the pipeline (zero when idle)
//   pipe_result                   : ciphertext leaving the pipeline LAT clocks later
//   rsp_valid/ready               : response handshake (pop = both high)
//   rsp_data/src/tag              : ciphertext, originating requester and its tag
//   busy                          : something is in flight or buffered
// ----------------------------------------------------------------------------
module aes_pipe_sched
    import aes_pipe_sched_pkg::*;
#(
    parameter int LAT        = LAT_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int TAG_W      = TAG_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [BLOCK_W-1:0]   req0_data,
    input  logic [BLOCK_W-1:0]   req0_key,
    input  logic [TAG_W-1:0]     req0_tag,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [BLOCK_W-1:0]   req1_data,
    input  logic [BLOCK_W-1:0]   req1_key,
    input  logic [TAG_W-1:0]     req1_tag,
    output logic [BLOCK_W-1:0]   pipe_data,
    output logic [BLOCK_W-1:0]   pipe_key,
    input  logic [BLOCK_W-1:0]   pipe_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BLOCK_W-1:0]   rsp_data,
    output logic                 rsp_src,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic                 busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int INF_W = $clog2(LAT + 1);
    localparam int REC_W = BLOCK_W + 1 + TAG_W;

    logic [LAT-1:0]   sr_valid;
    logic             sr_src [LAT];
    logic [TAG_W-1:0] sr_tag [LAT];

    logic [INF_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic [REC_W-1:0] wr_rec;
    logic [REC_W-1:0] rd_rec;

    src_e             last_src;
    src_e             grant_src;
    logic             issue_ok;
    logic             accept;
    logic             retire;
    logic             pop;

    // Credit check: every block already accepted owns a FIFO slot until it
    // is popped, so issuing is allowed only while blocks in the pipeline
    // plus blocks in the FIFO leave at least one slot free. This guarantees
    // the FIFO can always absorb whatever the pipeline retires.
    // The ready outputs are also forced low while reset is held, which in
    // turn keeps pipe_data/pipe_key at zero during reset.
    always_comb begin
        issue_ok   = (int'(inflight) + int'(fifo_count)) < FIFO_DEPTH;
        grant_src  = rr_pick(req0_valid, req1_valid, last_src);
        req0_ready = reset && issue_ok && req0_valid && (grant_src == SRC_REQ0);
        req1_ready = reset && issue_ok && req1_valid && (grant_src == SRC_REQ1);
        accept     = req0_ready || req1_ready;
        pipe_data  = '0;
        pipe_key   = '0;
        if (accept) begin
            pipe_data = (grant_src == SRC_REQ1) ? req1_data : req0_data;
            pipe_key  = (grant_src == SRC_REQ1) ? req1_key  : req0_key;
        end
    end

    // Round-robin pointer only moves when a block is actually accepted.
    // Reset value makes req0 win the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_src <= SRC_REQ1;
        end else if (accept) begin
            last_src <= grant_src;
        end
    end

    // Valid bits of the latency tracker. Each slot mirrors one pipeline
    // stage; clearing them on reset is what makes stale pipe_result values
    // harmless after a mid-operation reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_valid <= '0;
        end else begin
            sr_valid[0] <= accept;
            for (int i = 1; i < LAT; i++) begin
                sr_valid[i] <= sr_valid[i-1];
            end
        end
    end

    // Source and tag ride alongside the valid bits; they are only looked at
    // when the matching valid is set, so they need no reset.
    always_ff @(posedge clk) begin
        sr_src[0] <= grant_src;
        sr_tag[0] <= (grant_src == SRC_REQ1) ? req1_tag : req0_tag;
        for (int i = 1; i < LAT; i++) begin
            sr_src[i] <= sr_src[i-1];
            sr_tag[i] <= sr_tag[i-1];
        end
    end

    assign retire = sr_valid[LAT-1];

    // Running count of occupied tracker slots, kept as a counter so the
    // credit check does not need a popcount over LAT bits. Insert and
    // retire in the same cycle cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
        end else begin
            case ({accept, retire})
                2'b10:   inflight <= inflight + INF_W'(1);
                2'b01:   inflight <= inflight - INF_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // The oldest tracker slot lines up with the pipeline output, so the
    // ciphertext is paired with its src/tag as it is written.
    assign wr_rec = {pipe_result, sr_src[LAT-1], sr_tag[LAT-1]};

    aes_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_rsp_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (retire),
        .wr_data (wr_rec),
        .rd_en   (pop),
        .rd_data (rd_rec),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Response side: the FIFO head is presented directly.
    always_comb begin
        rsp_valid = !fifo_empty;
        pop       = rsp_valid && rsp_ready;
        rsp_data  = rd_rec[REC_W-1 -: BLOCK_W];
        rsp_src   = rd_rec[TAG_W];
        rsp_tag   = rd_rec[TAG_W-1:0];
        busy      = (inflight != '0) || !fifo_empty;
    end

endmodule

// File: tb/tb_aes_pipe_sched.sv
// ----------------------------------------------------------------------------
// tb_aes_pipe_sched
// Drives aes_pipe_sched with directed and random traffic. A behavioural AES
// pipeline (real AES-128, LAT clocks deep) feeds pipe_result, and a queue of
// accepted-but-not-popped blocks predicts ready, pipe, rsp and busy outputs.
// ----------------------------------------------------------------------------
module tb_aes_pipe_sched;
    import aes_pipe_sched_pkg::*;

    localparam int LAT   = LAT_DEFAULT;
    localparam int DEPTH = FIFO_DEPTH_DEFAULT;
    localparam int TAG_W = TAG_W_DEFAULT;

    logic               clk;
    logic               reset;
    logic               req0_valid, req1_valid;
    logic               req0_ready, req1_ready;
    logic [127:0]       req0_data, req0_key, req1_data, req1_key;
    logic [TAG_W-1:0]   req0_tag, req1_tag;
    logic [127:0]       pipe_data, pipe_key, pipe_result;
    logic               rsp_valid, rsp_ready;
    logic [127:0]       rsp_data;
    logic               rsp_src;
    logic [TAG_W-1:0]   rsp_tag;
    logic               busy;

    int                 comp_cnt = 0;
    int                 fail_cnt = 0;

    // Model state: every accepted block not yet popped, with the cycle from
    // which it may appear at the response port.
    rsp_rec_t           exp_q[$];
    int                 avail_q[$];
    int                 cyc = 0;
    logic               last_g = 1'b1;

    logic [7:0]         sbox_tab [256];
    logic [127:0]       pd_q [LAT-1];
    logic [127:0]       pk_q [LAT-1];

    aes_pipe_sched #(
        .LAT        (LAT),
        .FIFO_DEPTH (DEPTH),
        .TAG_W      (TAG_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_data   (req0_data),
        .req0_key    (req0_key),
        .req0_tag    (req0_tag),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_data   (req1_data),
        .req1_key    (req1_key),
        .req1_tag    (req1_tag),
        .pipe_data   (pipe_data),
        .pipe_key    (pipe_key),
        .pipe_result (pipe_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_src     (rsp_src),
        .rsp_tag     (rsp_tag),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- AES-128 reference ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    initial begin
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_tab[x] = s;
        end
    end

    function automatic logic [127:0] aesEnc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] rk [16];
        logic [7:0] tmp [4];
        logic [7:0] rcon, a0, a1, a2, a3;
        logic [127:0] res;
        rcon = 8'h01;
        for (int i = 0; i < 16; i++) begin
            rk[i] = key[127-8*i -: 8];
            s[i]  = pt[127-8*i -: 8] ^ rk[i];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[w + 4*c] = s[w + 4*((c + w) % 4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            tmp[0] = sbox_tab[rk[13]] ^ rcon;
            tmp[1] = sbox_tab[rk[14]];
            tmp[2] = sbox_tab[rk[15]];
            tmp[3] = sbox_tab[rk[12]];
            for (int i = 0; i < 4; i++)  rk[i] = rk[i] ^ tmp[i];
            for (int i = 4; i < 16; i++) rk[i] = rk[i] ^ rk[i-4];
            rcon = xt(rcon);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // External pipeline: what enters on one edge leaves as ciphertext on
    // pipe_result LAT-1 edges later, lining up with the last tracker stage.
    always @(posedge clk) begin
        pd_q[0] <= pipe_data;
        pk_q[0] <= pipe_key;
        for (int i = 1; i < LAT - 1; i++) begin
            pd_q[i] <= pd_q[i-1];
            pk_q[i] <= pk_q[i-1];
        end
        pipe_result <= aesEnc(pd_q[LAT-2], pk_q[LAT-2]);
    end

    // ---------------- checking and stimulus ----------------
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        comp_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: drive inputs, compare outputs against the model,
    // cross the edge and advance the model.
    task automatic applyStimulus(input logic v0, input logic v1, input logic rdy,
                                 input logic [127:0] d0, input logic [127:0] k0, input logic [TAG_W-1:0] t0,
                                 input logic [127:0] d1, input logic [127:0] k1, input logic [TAG_W-1:0] t1,
                                 output logic acc, output logic src, output logic popped);
        logic permitted, g, e_r0, e_r1, e_acc, e_rv;
        req0_valid = v0; req0_data = d0; req0_key = k0; req0_tag = t0;
        req1_valid = v1; req1_data = d1; req1_key = k1; req1_tag = t1;
        rsp_ready  = rdy;
        #1;
        permitted = exp_q.size() < DEPTH;
        g     = (v0 && v1) ? !last_g : v1;
        e_r0  = permitted && v0 && !g;
        e_r1  = permitted && v1 && g;
        e_acc = e_r0 || e_r1;
        e_rv  = (exp_q.size() > 0) && (cyc >= avail_q[0]);
        checkOutput("req0_ready", 128'(req0_ready), 128'(e_r0));
        checkOutput("req1_ready", 128'(req1_ready), 128'(e_r1));
        checkOutput("pipe_data", pipe_data, e_acc ? (g ? d1 : d0) : 128'h0);
        checkOutput("pipe_key", pipe_key, e_acc ? (g ? k1 : k0) : 128'h0);
        checkOutput("rsp_valid", 128'(rsp_valid), 128'(e_rv));
        checkOutput("busy", 128'(busy), 128'(exp_q.size() > 0));
        if (e_rv) begin
            checkOutput("rsp_data", rsp_data, exp_q[0].data);
            checkOutput("rsp_src", 128'(rsp_src), 128'(exp_q[0].src));
            checkOutput("rsp_tag", 128'(rsp_tag), 128'(exp_q[0].tag));
        end
        acc    = (req0_ready && v0) || (req1_ready && v1);
        src    = req1_ready && v1;
        popped = rsp_valid && rdy;
        @(posedge clk);
        cyc++;
        if (e_rv && rdy) begin
            void'(exp_q.pop_front());
            void'(avail_q.pop_front());
        end
        if (e_acc) begin
            exp_q.push_back('{data: aesEnc(g ? d1 : d0, g ? k1 : k0), src: g, tag: (g ? t1 : t0)});
            avail_q.push_back(cyc + LAT);
            last_g = g;
        end
        #1;
    endtask

    task automatic randCycle(input logic v0, input logic v1, input logic rdy,
                             output logic acc, output logic src, output logic popped);
        applyStimulus(v0, v1, rdy, rnd128(), rnd128(), TAG_W'($urandom),
                      rnd128(), rnd128(), TAG_W'($urandom), acc, src, popped);
    endtask

    task automatic doReset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        reset = 1'b0;
        #1;
        checkOutput("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_req0_ready", 128'(req0_ready), 128'(0));
        checkOutput("rst_req1_ready", 128'(req1_ready), 128'(0));
        checkOutput("rst_pipe_data", pipe_data, 128'h0);
        checkOutput("rst_pipe_key", pipe_key, 128'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_q.delete();
        avail_q.delete();
        last_g = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic acc, src, pop;
        int   n, nacc, npop;
        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_data = '0; req0_key = '0; req0_tag = '0;
        req1_data = '0; req1_key = '0; req1_tag = '0;
        @(posedge clk);
        #1;
        doReset();

        // Idle cycles: pipe must stay zero.
        for (int i = 0; i < 3; i++) randCycle(1'b0, 1'b0, 1'b1, acc, src, pop);

        // FIPS-197 known answer through the behavioural pipeline.
        applyStimulus(1'b1, 1'b0, 1'b1,
                      128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, TAG_W'(3),
                      128'h0, 128'h0, TAG_W'(0), acc, src, pop);
        checkOutput("kat_accept", 128'(acc), 128'(1));
        n = 0;
        while (!rsp_valid && n < 4 * LAT) begin
            randCycle(1'b0, 1'b0, 1'b0, acc, src, pop);
            n++;
        end
        checkOutput("kat_latency", 128'(n), 128'(LAT));
        checkOutput("kat_data", rsp_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        checkOutput("kat_src", 128'(rsp_src), 128'(0));
        checkOutput("kat_tag", 128'(rsp_tag), 128'(3));
        randCycle(1'b0, 1'b0, 1'b1, acc, src, pop);

        // Both requesters valid: grants alternate starting with req0.
        doReset();
        for (int i = 0; i < 8; i++) begin
            randCycle(1'b1, 1'b1, 1'b1, acc, src, pop);
            checkOutput("alt_accept", 128'(acc), 128'(1));
            checkOutput("alt_src", 128'(src), 128'(i % 2));
        end
        for (int i = 0; i < 20; i++) randCycle(1'b0, 1'b0, 1'b1, acc, src, pop);

        // Back-pressure: exactly DEPTH accepts, then drain in order.
        nacc = 0;
        for (int i = 0; i < 30; i++) begin
            randCycle(1'b1, 1'b1, 1'b0, acc, src, pop);
            nacc += int'(acc);
        end
        checkOutput("stall_accepts", 128'(nacc), 128'(DEPTH));
        nacc = 0; npop = 0;
        for (int i = 0; i < 40; i++) begin
            randCycle(1'b1, 1'b1, 1'b1, acc, src, pop);
            nacc += int'(acc);
            npop += int'(pop);
        end
        checkOutput("drain_pops", 128'(npop >= DEPTH), 128'(1));
        checkOutput("resume_accepts", 128'(nacc > 0), 128'(1));
        for (int i = 0; i < 30; i++) randCycle(1'b0, 1'b0, 1'b1, acc, src, pop);

        // Streaming: one accept per cycle with the consumer always ready.
        nacc = 0;
        for (int i = 0; i < 40; i++) begin
            randCycle(1'b1, 1'b0, 1'b1, acc, src, pop);
            nacc += int'(acc);
        end
        checkOutput("stream_accepts", 128'(nacc), 128'(40));
        for (int i = 0; i < 20; i++) randCycle(1'b0, 1'b0, 1'b1, acc, src, pop);

        // Only req1 asking: it wins every cycle.
        nacc = 0;
        for (int i = 0; i < 10; i++) begin
            randCycle(1'b0, 1'b1, 1'b1, acc, src, pop);
            nacc += int'(acc && src);
        end
        checkOutput("req1_only_grants", 128'(nacc), 128'(10));
        for (int i = 0; i < 20; i++) randCycle(1'b0, 1'b0, 1'b1, acc, src, pop);

        // Reset with 3 buffered and 5 in flight; nothing stale may follow.
        for (int i = 0; i < 3; i++) randCycle(1'b1, 1'b0, 1'b0, acc, src, pop);
        for (int i = 0; i < LAT + 1; i++) randCycle(1'b0, 1'b0, 1'b0, acc, src, pop);
        checkOutput("buffered_valid", 128'(rsp_valid), 128'(1));
        for (int i = 0; i < 5; i++) randCycle(1'b0, 1'b1, 1'b0, acc, src, pop);
        for (int i = 0; i < 2; i++) randCycle(1'b0, 1'b0, 1'b0, acc, src, pop);
        doReset();
        npop = 0;
        for (int i = 0; i < 30; i++) begin
            randCycle(1'b0, 1'b0, 1'b1, acc, src, pop);
            npop += int'(pop);
        end
        checkOutput("no_stale_rsp", 128'(npop), 128'(0));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            randCycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) != 0), acc, src, pop);
        end
        for (int i = 0; i < 40; i++) randCycle(1'b0, 1'b0, 1'b1, acc, src, pop);
        checkOutput("final_idle_busy", 128'(busy), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, fail_cnt);
        $finish;
    end

endmodule
